// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM states, parity
// polarity constants and the data-length clamp used when a frame is latched.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_HOLD
  } rx_state_t;

  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam int   MIN_DATA_LEN = 5;

  // Requested lengths outside MIN_DATA_LEN..max_len saturate to the nearest limit.
  function automatic logic [3:0] clamp_len(input logic [3:0] req, input int max_len);
    if (int'(req) < MIN_DATA_LEN) return 4'(MIN_DATA_LEN);
    if (int'(req) > max_len) return 4'(max_len);
    return req;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; the head word is visible while not empty
// and reads as zero when empty. A push on full is accepted only if a pop frees a slot.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     rx_clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with error tagging and receive FIFO.
// Define UART_RX_MAJORITY_EN to decide each bit by a 3-sample majority vote.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = 16,
  parameter int FIFO_D = 8
) (
  input  logic                      rx_clk,
  input  logic                      rst,
  input  logic                      rx_en,
  input  logic                      rx,
  input  logic                      parity_en,
  input  logic                      parity_type,
  input  logic [3:0]                data_len,
  input  logic                      stop2,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_perr,
  output logic                      rd_ferr,
  output logic                      rd_valid,
  output logic [$clog2(FIFO_D):0]   fifo_level,
  output logic                      overrun,
  output logic                      break_det,
  input  logic                      err_clr
);

  localparam int CW = $clog2(OSR);

  logic [1:0]          sync_q;
  logic                rx_s;
  logic                rx_prev;
  rx_state_t           state;
  logic [CW-1:0]       cnt;
  logic [3:0]          len_q;
  logic                par_en_q;
  logic                par_type_q;
  logic                stop2_q;
  logic [3:0]          bit_cnt;
  logic [DATA_W-1:0]   bit_mask;
  logic [DATA_W-1:0]   data_q;
  logic                perr_q;
  logic                ferr_q;
  logic                zero_q;
  logic                push_q;
  logic                bit_val;
  logic                at_sample;
  logic                at_end;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W+1:0]   head;

  assign rx_s = sync_q[1];

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx};
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_AT = OSR / 2;
  logic samp_a;
  logic samp_b;

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (cnt == CW'(OSR / 2 - 2)) samp_a <= rx_s;
      if (cnt == CW'(OSR / 2 - 1)) samp_b <= rx_s;
    end
  end

  assign bit_val = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
`else
  localparam int SAMPLE_AT = OSR / 2 - 1;
  assign bit_val = rx_s;
`endif

  assign at_sample = (cnt == CW'(SAMPLE_AT));
  assign at_end    = (cnt == CW'(OSR - 1));

  // The word is pushed from the last stop bit's mid-point, then the FSM re-arms
  // at once so a start bit immediately following the stop bit is not missed.
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      len_q      <= 4'(MIN_DATA_LEN);
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      stop2_q    <= 1'b0;
      bit_cnt    <= '0;
      bit_mask   <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      push_q     <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      break_det <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_en && rx_prev && !rx_s) begin
            state      <= ST_START;
            cnt        <= '0;
            len_q      <= clamp_len(data_len, DATA_W);
            par_en_q   <= parity_en;
            par_type_q <= parity_type;
            stop2_q    <= stop2;
            bit_cnt    <= '0;
            bit_mask   <= DATA_W'(1);
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: begin
          cnt <= at_end ? '0 : cnt + 1'b1;
          if (at_sample) begin
            case (state)
              ST_START: begin
                if (bit_val) state <= ST_IDLE;
              end
              ST_DATA: begin
                if (bit_val) begin
                  data_q <= data_q | bit_mask;
                  zero_q <= 1'b0;
                end
                bit_mask <= bit_mask << 1;
              end
              ST_PARITY: begin
                perr_q <= ((^data_q) ^ bit_val) != par_type_q;
                if (bit_val) zero_q <= 1'b0;
              end
              ST_STOP1: begin
                if (!bit_val && zero_q) begin
                  break_det <= 1'b1;
                  state     <= ST_HOLD;
                end else begin
                  ferr_q <= ferr_q | !bit_val;
                  if (!stop2_q) begin
                    push_q <= 1'b1;
                    state  <= ST_IDLE;
                  end
                end
              end
              ST_STOP2: begin
                ferr_q <= ferr_q | !bit_val;
                push_q <= 1'b1;
                state  <= ST_IDLE;
              end
              default: ;
            endcase
          end
          if (at_end) begin
            case (state)
              ST_START:  state <= ST_DATA;
              ST_DATA: begin
                if (bit_cnt == len_q - 4'd1) state <= par_en_q ? ST_PARITY : ST_STOP1;
                else bit_cnt <= bit_cnt + 4'd1;
              end
              ST_PARITY: state <= ST_STOP1;
              ST_STOP1:  state <= ST_STOP2;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // A set in the same cycle as err_clr wins so a fresh drop is never lost.
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (push_q && fifo_full && !(rd_en && !fifo_empty)) begin
      overrun <= 1'b1;
    end else if (err_clr) begin
      overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .rx_clk (rx_clk),
    .rst    (rst),
    .push   (push_q),
    .wdata  ({perr_q, ferr_q, data_q}),
    .pop    (rd_en),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign rd_data  = head[DATA_W-1:0];
  assign rd_ferr  = head[DATA_W];
  assign rd_perr  = head[DATA_W+1];
  assign rd_valid = !fifo_empty;

endmodule
